boot_chime_seq: RTL
===================

Name: boot_chime_seq

Overview:
- Sequences the channel-1 square-wave generator to play the two-note power-on chime (0x783 then 0x7c1).
- Also shares the generator with a host requester that can fire single notes when no chime is running.
- Sits between boot/control logic and the generator's start_sound/freq inputs, on the same 8 MHz clock.

Parameters:
- FRAME_DIV, 133333: clk_8m cycles per frame tick (~60 Hz); must be >= 4.
- NOTE0_FREQ, 11'h783: 11-bit frequency code for note 0.
- NOTE0_LEN, 8'd6: note 0 duration in frame ticks before note 1 fires.
- NOTE1_FREQ, 11'h7c1: 11-bit frequency code for note 1.
- NOTE1_LEN, 8'd60: note 1 duration in frame ticks before the sequence completes.

Ports:
- clk_8m  in  1  system clock, 8 MHz
- rst  in  1  synchronous reset, active-high
- play  in  1  start chime request, sampled each cycle
- abort  in  1  terminate a running chime
- host_start  in  1  host single-note request
- host_freq  in  11  host note frequency code
- start_sound  out  1  one-cycle restart strobe to the generator
- freq  out  11  frequency code to the generator; valid when start_sound=1
- busy  out  1  chime sequence in progress
- done  out  1  one-cycle pulse when the chime completes normally
- host_ack  out  1  one-cycle pulse when a host request is accepted

Behaviour:
- Interface: one clock, clk_8m. Reset rst is synchronous and active-high.
- Reset values:
  - state=IDLE, idx=0, start_sound=0, freq=0, busy=0, done=0, host_ack=0.
  - Frame divider=FRAME_DIV-1; length counter=0.
- Frame divider:
  - Down-counter; frame_tick=1 for one cycle when it reaches 0, then it reloads FRAME_DIV-1.
  - It is reloaded with FRAME_DIV-1 on the edge that accepts play, so the first tick falls exactly FRAME_DIV cycles after acceptance.
- States are IDLE, FIRE and HOLD. All outputs are registered or decoded from state; there is no combinational path from inputs to outputs.
- IDLE:
  - play=1 → idx=0, go to FIRE.
  - Otherwise host_start=1 → next cycle start_sound=1, freq=host_freq, host_ack=1; state stays IDLE.
  - play has priority over host_start in the same cycle; the host request is dropped with no ack.
- FIRE (lasts exactly one cycle):
  - start_sound=1; freq=NOTE0_FREQ or NOTE1_FREQ per idx.
  - Length counter loads NOTE0_LEN or NOTE1_LEN; go to HOLD.
- HOLD:
  - On frame_tick with counter > 1: decrement.
  - On frame_tick with counter <= 1: if idx=0, set idx=1 and go to FIRE; if idx=1, go to IDLE with done=1 for one cycle.
  - A length of 0 behaves as 1.
- Timing:
  - play accepted at edge t → note 0 strobe in cycle t+1.
  - Note 1 strobe at t+NOTE0_LEN*FRAME_DIV+1.
  - done and return to IDLE at t+(NOTE0_LEN+NOTE1_LEN)*FRAME_DIV+1.
- busy=1 whenever state != IDLE.
- freq holds its last value between strobes and never changes while start_sound=0, except at reset.
- While busy:
  - play is ignored (no restart).
  - host_start is dropped with host_ack=0; it is not queued.
- abort:
  - When state != IDLE: next state is IDLE, idx=0, no start_sound, no done. abort has priority over frame_tick and FIRE.
  - abort in IDLE has no effect; it does not block play or host_start in the same cycle.
- rst mid-sequence returns every register to its reset value on the next edge; no strobe or done is emitted.
- Only 11-bit codes are passed; the block does not interpret frequency or range-check it.

Test Plan:
- Bench config FRAME_DIV=10, NOTE0_LEN=2, NOTE1_LEN=3, default freqs.
- play pulsed at cycle 0 → start_sound only in cycles 1 (freq=0x783) and 21 (freq=0x7c1); busy=1 cycles 1..50; done=1 only in cycle 51; busy=0 from cycle 51.
- play pulsed again at cycles 5 and 30 during the run above → no extra strobes; timing identical to the previous scenario.
- host_start with host_freq=0x6d6 in IDLE → cycle+1: start_sound=1, freq=0x6d6, host_ack=1; busy stays 0. play and host_start in the same cycle → chime starts, host_ack never asserts.
- play at 0, abort at cycle 15 → busy=0 from cycle 16; no strobe at 21, no done. A new play at cycle 40 → strobe at 41 with freq=0x783.
- rst asserted at cycle 25 mid-HOLD → all outputs at reset values from cycle 26; freq=0; no done. With NOTE0_LEN=0, note 1 strobe still at cycle 11.

Source files
------------

// File: rtl/boot_chime_seq_if.sv
// Handshake bundle between boot/host control and the channel-1 chime sequencer.
// Control logic drives the requests; the sequencer drives the generator-side outputs.
interface boot_chime_seq_if;
  logic        play;
  logic        abort;
  logic        host_start;
  logic [10:0] host_freq;
  logic        start_sound;
  logic [10:0] freq;
  logic        busy;
  logic        done;
  logic        host_ack;

  modport master (
    output play, abort, host_start, host_freq,
    input  start_sound, freq, busy, done, host_ack
  );

  modport slave (
    input  play, abort, host_start, host_freq,
    output start_sound, freq, busy, done, host_ack
  );
endinterface

// File: rtl/boot_chime_seq.sv
// Two-note power-on chime sequencer for the channel-1 square-wave generator,
// also arbitrating single-note host requests while no chime is running.
module boot_chime_seq #(
  parameter int unsigned FRAME_DIV  = 133333,
  parameter logic [10:0] NOTE0_FREQ = 11'h783,
  parameter logic [7:0]  NOTE0_LEN  = 8'd6,
  parameter logic [10:0] NOTE1_FREQ = 11'h7c1,
  parameter logic [7:0]  NOTE1_LEN  = 8'd60
) (
  input  logic             clk_8m,
  input  logic             rst,
  boot_chime_seq_if.slave  bus
);

  localparam int unsigned DIV_W = $clog2(FRAME_DIV);
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(FRAME_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    FIRE,
    HOLD
  } state_t;

  state_t           state_q, state_d;
  logic             idx_q, idx_d;
  logic [7:0]       len_q, len_d;
  logic [DIV_W-1:0] div_q;
  logic             div_reload;
  logic             frame_tick;
  logic             start_q, start_d;
  logic [10:0]      freq_q, freq_d;
  logic             done_q, done_d;
  logic             ack_q, ack_d;

  assign frame_tick = (div_q == '0);

  // Accepting play realigns the divider so note timing is relative to the request.
  always_ff @(posedge clk_8m) begin
    if (rst || div_reload || frame_tick) begin
      div_q <= DIV_LOAD;
    end else begin
      div_q <= div_q - DIV_W'(1);
    end
  end

  always_ff @(posedge clk_8m) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 1'b0;
      len_q   <= '0;
      start_q <= 1'b0;
      freq_q  <= '0;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      start_q <= start_d;
      freq_q  <= freq_d;
      done_q  <= done_d;
      ack_q   <= ack_d;
    end
  end

  // The strobe and its frequency are registered on the edge that enters FIRE,
  // so start_sound is high exactly during the FIRE cycle.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    len_d      = len_q;
    start_d    = 1'b0;
    freq_d     = freq_q;
    done_d     = 1'b0;
    ack_d      = 1'b0;
    div_reload = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.play) begin
          idx_d      = 1'b0;
          state_d    = FIRE;
          start_d    = 1'b1;
          freq_d     = NOTE0_FREQ;
          div_reload = 1'b1;
        end else if (bus.host_start) begin
          start_d = 1'b1;
          freq_d  = bus.host_freq;
          ack_d   = 1'b1;
        end
      end

      FIRE: begin
        if (bus.abort) begin
          state_d = IDLE;
          idx_d   = 1'b0;
        end else begin
          len_d   = idx_q ? NOTE1_LEN : NOTE0_LEN;
          state_d = HOLD;
        end
      end

      HOLD: begin
        if (bus.abort) begin
          state_d = IDLE;
          idx_d   = 1'b0;
        end else if (frame_tick) begin
          if (len_q > 8'd1) begin
            len_d = len_q - 8'd1;
          end else if (!idx_q) begin
            idx_d   = 1'b1;
            state_d = FIRE;
            start_d = 1'b1;
            freq_d  = NOTE1_FREQ;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.start_sound = start_q;
  assign bus.freq        = freq_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = done_q;
  assign bus.host_ack    = ack_q;

endmodule
